// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, working-state type, round helper functions and FSM states.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUNDS = 2'd1,
    DIGEST = 2'd2
  } state_e;

  // Field a sits in the top word, so a packed state reads as {H0,...,H7}.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic work_t iv_state();
    return '{a: IV[0], b: IV[1], c: IV[2], d: IV[3], e: IV[4], f: IV[5], g: IV[6], h: IV[7]};
  endfunction

  function automatic work_t add_state(input work_t x, input work_t y);
    return '{a: x.a + y.a, b: x.b + y.b, c: x.c + y.c, d: x.d + y.d,
             e: x.e + y.e, f: x.f + y.f, g: x.g + y.g, h: x.h + y.h};
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 round, purely combinational; kept separate so the adder chain can be retimed alone.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       work_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output work_t       work_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = work_i.h + big_sigma1(work_i.e) + ch(work_i.e, work_i.f, work_i.g) + k_i + w_i;
  assign t2 = big_sigma0(work_i.a) + maj(work_i.a, work_i.b, work_i.c);

  assign work_o = '{a: t1 + t2, b: work_i.a, c: work_i.b, d: work_i.c,
                    e: work_i.d + t1, f: work_i.e, g: work_i.f, h: work_i.g};

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 block compression: drives the schedule index, runs the rounds, folds into H.
// start to digest_valid is NUM_ROUNDS+3 cycles; no backpressure, start while busy is dropped.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64,
  parameter int W_LAT      = 1
) (
  input  logic         clk,
  input  logic         reset_n,      // active-high synchronous reset despite the name
  input  logic         start,
  input  logic         first_blk,
  output logic [5:0]   round_idx,
  output logic         msg_req,
  input  logic [31:0]  w_in,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
);

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] FIRST_RND = CNT_W'(W_LAT);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_ROUNDS + W_LAT - 1);
  localparam logic [CNT_W-1:0] MSG_WORDS = CNT_W'(16);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  work_t            work_q, work_d;
  work_t            h_q, h_d;
  logic             dv_q, dv_d;

  work_t            rnd_out;
  logic [5:0]       t_idx;

  // W_t arrives W_LAT cycles after its index was issued, so the round index lags cnt.
  assign t_idx = 6'(cnt_q - FIRST_RND);

  sha256_round u_round (
    .work_i (work_q),
    .k_i    (K[t_idx]),
    .w_i    (w_in),
    .work_o (rnd_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    h_d       = h_q;
    dv_d      = 1'b0;
    round_idx = 6'd0;
    msg_req   = 1'b0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (first_blk) h_d = iv_state();
          work_d  = first_blk ? iv_state() : h_q;
          cnt_d   = '0;
          state_d = ROUNDS;
        end
      end
      ROUNDS: begin
        if (cnt_q < ISSUE_END) begin
          round_idx = cnt_q[5:0];
          msg_req   = (cnt_q < MSG_WORDS);
        end
        if (cnt_q >= FIRST_RND) work_d = rnd_out;
        if (cnt_q == LAST_CNT) state_d = DIGEST;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      DIGEST: begin
        h_d     = add_state(h_q, work_q);
        dv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      h_q     <= iv_state();
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      h_q     <= h_d;
      dv_q    <= dv_d;
    end
  end

  assign digest_valid = dv_q;
  assign digest       = h_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Bench for sha256_compress: behavioural SHA-256 model, schedule source, per-cycle compare and known vectors.
module tb_sha256_compress;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         first_blk;
  logic [5:0]   round_idx;
  logic         msg_req;
  logic [31:0]  w_in;
  logic         busy;
  logic         digest_valid;
  logic [255:0] digest;

  sha256_compress dut (
    .clk          (clk),
    .reset_n      (rst),
    .start        (start),
    .first_blk    (first_blk),
    .round_idx    (round_idx),
    .msg_req      (msg_req),
    .w_in         (w_in),
    .busy         (busy),
    .digest_valid (digest_valid),
    .digest       (digest)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] TIV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] DG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] wsched(input logic [511:0] blk, input int t);
    logic [31:0] w [64];
    for (int i = 0; i <= t; i++) begin
      if (i < 16) w[i] = blk[511 - 32*i -: 32];
      else w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end
    return w[t];
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + TK[i] + wsched(blk, i);
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: m_k counts cycles since the block was accepted (0 = never started, 67 = digest cycle).
  logic [511:0] cur_blk;
  logic [511:0] m_blk  = '0;
  logic [255:0] m_H    = TIV;
  logic [255:0] m_next = '0;
  int           m_k    = 0;
  logic         chk_en = 1'b0;
  int           dv_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_k <= 0;
      m_H <= TIV;
    end else if ((m_k == 0 || m_k == 67) && start) begin
      m_k    <= 1;
      m_blk  <= cur_blk;
      m_H    <= first_blk ? TIV : m_H;
      m_next <= compress(first_blk ? TIV : m_H, cur_blk);
    end else if (m_k == 67) begin
      m_k <= 0;
    end else if (m_k != 0) begin
      m_k <= m_k + 1;
      if (m_k == 66) m_H <= m_next;
    end
  end

  // Schedule source: W_t appears one cycle after round_idx=t.
  logic [5:0] widx;
  initial begin
    w_in = '0;
    forever begin
      @(negedge clk);
      widx = round_idx;
      @(posedge clk);
      #1 w_in = wsched(m_blk, int'(widx));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 256'(busy), 256'(m_k >= 1 && m_k <= 66));
      chk("digest_valid", 256'(digest_valid), 256'(m_k == 67));
      chk("round_idx", 256'(round_idx), (m_k >= 1 && m_k <= 64) ? 256'(m_k - 1) : 256'd0);
      chk("msg_req", 256'(msg_req), 256'(m_k >= 1 && m_k <= 16));
      chk("digest", digest, m_H);
      if (digest_valid === 1'b1) dv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [511:0] blk, input logic fb);
    cur_blk   = blk;
    first_blk = fb;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Returns ticks waited from call until digest_valid; flags a timeout as a failure.
  task automatic wait_dv(output int lat);
    lat = 0;
    while (digest_valid !== 1'b1 && lat < 300) begin
      tick();
      lat++;
    end
    if (digest_valid !== 1'b1) chk("dv_timeout", 256'(digest_valid), 256'd1);
  endtask

  initial begin
    int lat;
    int dv0;
    logic [511:0] rblk;
    rst = 1'b1; start = 1'b0; first_blk = 1'b0; cur_blk = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_digest", digest, TIV);
    chk("reset_busy", 256'(busy), 256'd0);
    rst = 1'b0;
    tick();

    do_start(BLK_ABC, 1'b1);
    wait_dv(lat);
    chk("abc_latency", 256'(lat + 1), 256'd67);
    chk("abc_digest", digest, DG_ABC);
    chk("model_abc", compress(TIV, BLK_ABC), DG_ABC);
    repeat (3) tick();

    do_start(BLK_EMPTY, 1'b1);
    wait_dv(lat);
    chk("empty_digest", digest, DG_EMPTY);

    // Second block starts in the digest_valid cycle of the first.
    do_start(BLK_TWO1, 1'b1);
    wait_dv(lat);
    do_start(BLK_TWO2, 1'b0);
    wait_dv(lat);
    chk("two_block_latency", 256'(lat + 1), 256'd67);
    chk("two_block_digest", digest, DG_TWO);
    repeat (2) tick();

    dv0 = dv_cnt;
    do_start(BLK_ABC, 1'b1);
    repeat (20) tick();
    cur_blk = BLK_EMPTY; first_blk = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_dv(lat);
    chk("ignored_start_digest", digest, DG_ABC);
    repeat (80) tick();
    chk("ignored_start_pulses", 256'(dv_cnt - dv0), 256'd1);

    do_start(BLK_EMPTY, 1'b1);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_busy", 256'(busy), 256'd0);
    chk("midreset_digest", digest, TIV);
    do_start(BLK_ABC, 1'b0);
    wait_dv(lat);
    chk("post_reset_abc", digest, DG_ABC);
    tick();

    for (int n = 0; n < 25; n++) begin
      int r;
      for (int i = 0; i < 16; i++) rblk[511 - 32*i -: 32] = $urandom;
      do_start(rblk, 1'($urandom_range(0, 1)));
      r = $urandom_range(0, 7);
      if (r == 0) begin
        repeat ($urandom_range(1, 64)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        if (r == 1) begin
          repeat ($urandom_range(1, 60)) tick();
          cur_blk = ~rblk; first_blk = 1'b1; start = 1'b1;
          tick();
          start = 1'b0;
        end
        wait_dv(lat);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
